// File: rtl/peak_tracker_pkg.sv
// Shared state encoding and default constants for the peak tracker family.
package peak_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int PW_RESET_DEFAULT = 5000;
  localparam int DATA_W_DEFAULT   = 12;
  localparam int PW_W_DEFAULT     = 15;

endpackage

// File: rtl/peak_hyst_cmp.sv
// Hysteresis compare: a sample beats the candidate only if it exceeds it by more than HYST.
module peak_hyst_cmp
  import peak_tracker_pkg::*;
#(
  parameter int                DATA_W = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] HYST   = '0
) (
  input  logic              cand_valid,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] cand,
  output logic              gt
);

  logic [DATA_W:0] thresh_s;

  // Threshold is one bit wider so cand + HYST never wraps below full scale.
  always_comb begin
    thresh_s = {1'b0, cand} + {1'b0, HYST};
    gt       = !cand_valid | ({1'b0, data} > thresh_s);
  end

endmodule

// File: rtl/peak_tracker.sv
// Tracks the largest ADC sample of a servo sweep and publishes it with the
// servo pulse widths and sample index at sweep end.
module peak_tracker
  import peak_tracker_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEFAULT,
  parameter int                PW_W     = PW_W_DEFAULT,
  parameter int                N_AXES   = 2,
  parameter int                CNT_W    = 16,
  parameter logic [DATA_W-1:0] HYST     = '0,
  parameter int                PW_RESET = PW_RESET_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   sweep_start,
  input  logic                   sweep_end,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  logic [DATA_W-1:0]      sample_data,
  input  logic [N_AXES*PW_W-1:0] pw_in,
  output logic                   new_max,
  output logic [DATA_W-1:0]      max_value,
  output logic [N_AXES*PW_W-1:0] pw_max,
  output logic [CNT_W-1:0]       max_idx,
  output logic                   result_valid,
  output logic                   sweep_done,
  output logic                   busy
);

  localparam logic [PW_W-1:0]        PW_RESET_V   = PW_W'(PW_RESET);
  localparam logic [N_AXES*PW_W-1:0] PW_RESET_ALL = {N_AXES{PW_RESET_V}};

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic                     cand_valid_r;
  logic [DATA_W-1:0]        cand_value_r;
  logic [N_AXES*PW_W-1:0]   cand_pw_r;
  logic [CNT_W-1:0]         cand_idx_r;
  logic [CNT_W-1:0]         count_r;
  logic                     gt_s;
  logic                     accept_s;
  logic                     take_s;
  logic                     in_done_s;

  peak_hyst_cmp #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_cmp (
    .cand_valid (cand_valid_r),
    .data       (sample_data),
    .cand       (cand_value_r),
    .gt         (gt_s)
  );

  // A sample in the same cycle as sweep_start belongs to the discarded sweep.
  assign accept_s  = sample_valid & sample_ready;
  assign take_s    = accept_s & ~sweep_start & gt_s;
  assign in_done_s = (state_r == DONE);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; DONE lasts exactly one cycle.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (sweep_start) state_nxt_s = SWEEP;
        else             state_nxt_s = IDLE;
      end
      SWEEP: begin
        if (sweep_start)    state_nxt_s = SWEEP;
        else if (sweep_end) state_nxt_s = DONE;
        else                state_nxt_s = SWEEP;
      end
      DONE: begin
        if (sweep_start) state_nxt_s = SWEEP;
        else             state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake and status decoded from the state register.
  always_comb begin
    sample_ready = 1'b0;
    busy         = 1'b0;
    case (state_r)
      IDLE:    begin sample_ready = 1'b0; busy = 1'b0; end
      SWEEP:   begin sample_ready = 1'b1; busy = 1'b1; end
      DONE:    begin sample_ready = 1'b0; busy = 1'b1; end
      default: begin sample_ready = 1'b0; busy = 1'b0; end
    endcase
  end

  // Candidate, saturating sample index and new_max pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cand_valid_r <= 1'b0;
      cand_value_r <= '0;
      cand_pw_r    <= PW_RESET_ALL;
      cand_idx_r   <= '0;
      count_r      <= '0;
      new_max      <= 1'b0;
    end else begin
      new_max <= take_s;
      if (sweep_start) begin
        cand_valid_r <= 1'b0;
        count_r      <= '0;
      end else if (accept_s) begin
        if (gt_s) begin
          cand_valid_r <= 1'b1;
          cand_value_r <= sample_data;
          cand_pw_r    <= pw_in;
          cand_idx_r   <= count_r;
        end
        if (count_r != {CNT_W{1'b1}}) begin
          count_r <= count_r + CNT_W'(1);
        end
      end
    end
  end

  // Publish registers; an empty sweep keeps the previous result but clears result_valid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      max_value    <= '0;
      pw_max       <= PW_RESET_ALL;
      max_idx      <= '0;
      result_valid <= 1'b0;
      sweep_done   <= 1'b0;
    end else begin
      sweep_done <= in_done_s;
      if (in_done_s) begin
        result_valid <= cand_valid_r;
        if (cand_valid_r) begin
          max_value <= cand_value_r;
          pw_max    <= cand_pw_r;
          max_idx   <= cand_idx_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_peak_tracker.sv
// Self-checking bench: three tracker instances (HYST=0, HYST=10, CNT_W=4) share
// stimulus and are compared against a queue-based sweep model.
module tb_peak_tracker;

  localparam logic [29:0] PWDEF = {15'd5000, 15'd5000};

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        sweep_start = 1'b0, sweep_end = 1'b0, sample_valid = 1'b0;
  logic [11:0] sample_data = 12'd0;
  logic [29:0] pw_in = 30'd0;

  logic        rdy0, rdy1, rdy2, nm0, nm1, nm2, rv0, rv1, rv2, sd0, sd1, sd2, bsy0, bsy1, bsy2;
  logic [11:0] mv0, mv1, mv2;
  logic [29:0] pw0, pw1, pw2;
  logic [15:0] idx0, idx1;
  logic [3:0]  idx2;

  int total = 0;
  int bad   = 0;

  // Model: accepted samples of the current sweep plus published results per instance.
  int          qd[$];
  logic [29:0] qp[$];
  int          mode;
  int          hyst[3] = '{0, 10, 0};
  int          imax[3] = '{65535, 65535, 15};
  int          pub_val[3];
  logic [29:0] pub_pw[3];
  int          pub_idx[3];
  logic        pub_rv[3];
  logic        exp_nm[3];
  logic        exp_done;

  peak_tracker u0 (
    .CLK(CLK), .RST(RST), .sweep_start(sweep_start), .sweep_end(sweep_end),
    .sample_valid(sample_valid), .sample_ready(rdy0), .sample_data(sample_data), .pw_in(pw_in),
    .new_max(nm0), .max_value(mv0), .pw_max(pw0), .max_idx(idx0),
    .result_valid(rv0), .sweep_done(sd0), .busy(bsy0));

  peak_tracker #(.HYST(12'd10)) u1 (
    .CLK(CLK), .RST(RST), .sweep_start(sweep_start), .sweep_end(sweep_end),
    .sample_valid(sample_valid), .sample_ready(rdy1), .sample_data(sample_data), .pw_in(pw_in),
    .new_max(nm1), .max_value(mv1), .pw_max(pw1), .max_idx(idx1),
    .result_valid(rv1), .sweep_done(sd1), .busy(bsy1));

  peak_tracker #(.CNT_W(4)) u2 (
    .CLK(CLK), .RST(RST), .sweep_start(sweep_start), .sweep_end(sweep_end),
    .sample_valid(sample_valid), .sample_ready(rdy2), .sample_data(sample_data), .pw_in(pw_in),
    .new_max(nm2), .max_value(mv2), .pw_max(pw2), .max_idx(idx2),
    .result_valid(rv2), .sweep_done(sd2), .busy(bsy2));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] pwp(input int h, input int v);
    return {15'(v), 15'(h)};
  endfunction

  function automatic int rnd_d();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 4095));
    else return 4060 + int'($urandom_range(0, 35));
  endfunction

  // Earliest sample that beats every earlier candidate by more than h.
  function automatic int winner(input int h);
    int w = 0;
    for (int i = 1; i < qd.size(); i++) if (qd[i] > qd[w] + h) w = i;
    return w;
  endfunction

  task automatic mdl_reset();
    mode = 0;
    qd.delete();
    qp.delete();
    exp_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pub_val[k] = 0; pub_pw[k] = PWDEF; pub_idx[k] = 0; pub_rv[k] = 1'b0; exp_nm[k] = 1'b0;
    end
  endtask

  task automatic check_dut(input int k, input logic nm, input logic sd, input logic [11:0] mv,
                           input logic [29:0] pw, input logic [15:0] idx, input logic rv,
                           input logic bsy, input logic rdy);
    chk($sformatf("d%0d.new_max", k), 64'(nm), 64'(exp_nm[k]));
    chk($sformatf("d%0d.sweep_done", k), 64'(sd), 64'(exp_done));
    chk($sformatf("d%0d.max_value", k), 64'(mv), 64'(pub_val[k]));
    chk($sformatf("d%0d.pw_max", k), 64'(pw), 64'(pub_pw[k]));
    chk($sformatf("d%0d.max_idx", k), 64'(idx), 64'(pub_idx[k]));
    chk($sformatf("d%0d.result_valid", k), 64'(rv), 64'(pub_rv[k]));
    chk($sformatf("d%0d.busy", k), 64'(bsy), 64'(mode != 0));
    chk($sformatf("d%0d.sample_ready", k), 64'(rdy), 64'(mode == 1));
  endtask

  task automatic check_outputs();
    check_dut(0, nm0, sd0, mv0, pw0, idx0, rv0, bsy0, rdy0);
    check_dut(1, nm1, sd1, mv1, pw1, idx1, rv1, bsy1, rdy1);
    check_dut(2, nm2, sd2, mv2, pw2, {12'd0, idx2}, rv2, bsy2, rdy2);
  endtask

  // One clock: drive inputs, advance the model across the edge, check just after it.
  task automatic tick(input logic s, input logic e, input logic v, input int d, input logic [29:0] pw);
    int w;
    sweep_start = s; sweep_end = e; sample_valid = v; sample_data = 12'(d); pw_in = pw;
    @(posedge CLK);
    exp_done = 1'b0;
    for (int k = 0; k < 3; k++) exp_nm[k] = 1'b0;
    case (mode)
      0: if (s) begin mode = 1; qd.delete(); qp.delete(); end
      1: begin
        if (s) begin
          qd.delete(); qp.delete();
        end else begin
          if (v) begin
            qd.push_back(d); qp.push_back(pw);
            for (int k = 0; k < 3; k++) exp_nm[k] = (winner(hyst[k]) == qd.size() - 1);
          end
          if (e) mode = 2;
        end
      end
      default: begin
        exp_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
          pub_rv[k] = (qd.size() > 0);
          if (qd.size() > 0) begin
            w = winner(hyst[k]);
            pub_val[k] = qd[w]; pub_pw[k] = qp[w];
            pub_idx[k] = (w > imax[k]) ? imax[k] : w;
          end
        end
        qd.delete(); qp.delete();
        mode = s ? 1 : 0;
      end
    endcase
    #1;
    check_outputs();
  endtask

  initial begin
    int  len;
    logic chained;
    mdl_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    check_outputs();
    chk("reset.pw_max", 64'(pw0), 64'(pwp(5000, 5000)));

    // Basic sweep, equal sample does not replace the earlier peak.
    tick(1'b1, 1'b0, 1'b0, 0, 30'd0);
    tick(1'b0, 1'b0, 1'b1, 100, pwp(6000, 7000));
    tick(1'b0, 1'b0, 1'b1, 300, pwp(6500, 7200));
    tick(1'b0, 1'b0, 1'b1, 300, pwp(6600, 7300));
    tick(1'b0, 1'b0, 1'b1, 200, pwp(6700, 7400));
    tick(1'b0, 1'b1, 1'b0, 0, 30'd0);
    tick(1'b0, 1'b0, 1'b0, 0, 30'd0);
    chk("t1.max_value", 64'(mv0), 64'd300);
    chk("t1.pw_max", 64'(pw0), 64'(pwp(6500, 7200)));
    chk("t1.max_idx", 64'(idx0), 64'd1);
    chk("t1.result_valid", 64'(rv0), 64'd1);
    tick(1'b0, 1'b0, 1'b0, 0, 30'd0);

    // Hysteresis, including a threshold above full scale.
    tick(1'b1, 1'b0, 1'b0, 0, 30'd0);
    tick(1'b0, 1'b0, 1'b1, 500, pwp(1, 2));
    tick(1'b0, 1'b0, 1'b1, 505, pwp(3, 4));
    chk("t2.rejected", 64'(nm1), 64'd0);
    tick(1'b0, 1'b0, 1'b1, 511, pwp(5, 6));
    tick(1'b0, 1'b1, 1'b0, 0, 30'd0);
    tick(1'b0, 1'b0, 1'b0, 0, 30'd0);
    chk("t2.max_value", 64'(mv1), 64'd511);
    chk("t2.max_idx", 64'(idx1), 64'd2);
    tick(1'b1, 1'b0, 1'b0, 0, 30'd0);
    tick(1'b0, 1'b0, 1'b1, 4090, pwp(7, 8));
    tick(1'b0, 1'b0, 1'b1, 4095, pwp(9, 10));
    tick(1'b0, 1'b1, 1'b0, 0, 30'd0);
    tick(1'b0, 1'b0, 1'b0, 0, 30'd0);
    chk("t2.no_wrap", 64'(mv1), 64'd4090);

    // Empty sweep keeps the previous value.
    tick(1'b1, 1'b0, 1'b0, 0, 30'd0);
    tick(1'b0, 1'b1, 1'b0, 0, 30'd0);
    tick(1'b0, 1'b0, 1'b0, 0, 30'd0);
    chk("t3.result_valid", 64'(rv0), 64'd0);
    chk("t3.kept", 64'(mv0), 64'd4095);

    // Sample alongside sweep_end; restart mid-sweep with a dropped sample.
    tick(1'b1, 1'b0, 1'b0, 0, 30'd0);
    tick(1'b0, 1'b1, 1'b1, 900, pwp(11, 12));
    tick(1'b0, 1'b0, 1'b0, 0, 30'd0);
    chk("t4.max_value", 64'(mv0), 64'd900);
    tick(1'b1, 1'b0, 1'b0, 0, 30'd0);
    tick(1'b0, 1'b0, 1'b1, 800, pwp(13, 14));
    tick(1'b1, 1'b0, 1'b1, 999, pwp(15, 16));
    tick(1'b0, 1'b0, 1'b1, 50, pwp(17, 18));
    tick(1'b0, 1'b1, 1'b0, 0, 30'd0);
    tick(1'b0, 1'b0, 1'b0, 0, 30'd0);
    chk("t5.max_value", 64'(mv0), 64'd50);
    chk("t5.max_idx", 64'(idx0), 64'd0);

    // Index saturation on the 4-bit counter instance.
    tick(1'b1, 1'b0, 1'b0, 0, 30'd0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b1, 100 + 10 * i, pwp(i, i + 1));
    tick(1'b0, 1'b1, 1'b0, 0, 30'd0);
    tick(1'b0, 1'b0, 1'b0, 0, 30'd0);
    chk("t6.idx_sat", 64'(idx2), 64'd15);
    chk("t6.max_value", 64'(mv2), 64'd290);

    // Asynchronous reset mid-sweep.
    tick(1'b1, 1'b0, 1'b0, 0, 30'd0);
    tick(1'b0, 1'b0, 1'b1, 700, pwp(19, 20));
    tick(1'b0, 1'b1, 1'b1, 710, pwp(21, 22));
    RST = 1'b1;
    #1;
    mdl_reset();
    check_outputs();
    @(negedge CLK);
    RST = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 0, 30'd0);

    // Randomised sweeps with noise in IDLE/DONE, restarts and back-to-back sweeps.
    chained = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!chained) tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_d(), 30'($urandom));
      len = int'($urandom_range(0, 20));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 19) == 0)
          tick(1'b1, 1'($urandom_range(0, 1)), 1'b1, rnd_d(), 30'($urandom));
        else
          tick(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), rnd_d(), 30'($urandom));
      end
      tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), rnd_d(), 30'($urandom));
      chained = ($urandom_range(0, 3) == 0);
      tick(chained, 1'b1, 1'b1, rnd_d(), 30'($urandom));
      if (!chained) tick(1'b0, 1'b1, 1'b1, rnd_d(), 30'($urandom));
    end
    tick(1'b0, 1'b1, 1'b0, 0, 30'd0);
    tick(1'b0, 1'b0, 1'b0, 0, 30'd0);
    tick(1'b0, 1'b0, 1'b0, 0, 30'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
